mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_defs_pkg.sv | 15 +
 rtl/mux_scan_ctrl_timer.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 115 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_defs_pkg.sv
// Shared definitions for the mux scan controller: state encoding and channel geometry.
package mux_scan_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } scan_state_t;

  localparam int SEL_W          = 2;
  localparam int NUM_CH         = 4;
  localparam int SETTLE_CYC_DEF = 2;

endpackage

// File: rtl/mux_scan_ctrl_timer.sv
// mux_settle_timer: settle counter with synchronous clear, count enable and terminal-count flag.
module mux_settle_timer #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  // The final settle cycle is the one whose count equals SETTLE_CYC-1.
  assign tc = (count == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps sel through channels 0..3, samples q into a 4-bit frame, hands it off on valid/ready.
// Optional MUX_SCAN_CNT_EN adds an 8-bit count of completed handshakes (frame_cnt).
module mux_scan_ctrl
  import mux_scan_defs::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             q,
  output logic [SEL_W-1:0] sel,
  output logic [NUM_CH-1:0] frame,
  output logic             frame_valid,
  input  logic             frame_ready,
`ifdef MUX_SCAN_CNT_EN
  output logic [7:0]       frame_cnt,
`endif
  output logic             busy
);

  scan_state_t       state, state_d;
  logic [SEL_W-1:0]  sel_d;
  logic [NUM_CH-1:0] frame_d;
  logic              valid_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc;
  logic              handshake;

  mux_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      frame       <= frame_d;
      frame_valid <= valid_d;
    end
  end

  always_comb begin
    state_d   = state;
    sel_d     = sel;
    frame_d   = frame;
    valid_d   = frame_valid;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          sel_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc)
          state_d = SAMPLE;
      end
      SAMPLE: begin
        frame_d[sel] = q;
        cnt_clr      = 1'b1;
        if (sel == SEL_W'(NUM_CH - 1)) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end else begin
          sel_d   = sel + 1'b1;
          state_d = SETTLE;
        end
      end
      HOLD: begin
        // Continuous mode restarts at channel 0 directly, skipping IDLE.
        if (frame_valid && frame_ready) begin
          handshake = 1'b1;
          valid_d   = 1'b0;
          sel_d     = '0;
          cnt_clr   = 1'b1;
          state_d   = cont ? SETTLE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef MUX_SCAN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if (handshake)
      frame_cnt <= frame_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scans against a scan-position model plus literal timing/frame checks.
// Define MUX_SCAN_CNT_EN to also exercise the frame counter wrap.
module tb_mux_scan_ctrl;

  localparam int S       = 2;
  localparam int SCAN_CY = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic       frame_ready;
  logic [3:0] mux_in;
  logic       q;
  logic [1:0] sel;
  logic [3:0] frame;
  logic       frame_valid;
  logic       busy;
`ifdef MUX_SCAN_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the 4-to-1 mux stage the controller drives.
  assign q = mux_in[sel];

  mux_scan_ctrl #(.SETTLE_CYC(S), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .q           (q),
    .sel         (sel),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
`ifdef MUX_SCAN_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .busy        (busy)
  );

  // Model: position within the current scan decides channel and sample points.
  logic       m_active;
  logic       m_hold;
  int         m_pos;
  logic [3:0] m_frame;
  logic       m_valid;
  logic [7:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_hold = 1'b0; m_pos = 0;
      m_frame = 4'b0000; m_valid = 1'b0; m_cnt = 8'd0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_pos = 0;
      end
    end else if (m_hold) begin
      if (frame_ready) begin
        m_hold = 1'b0; m_valid = 1'b0; m_cnt = m_cnt + 8'd1;
        if (cont) m_pos = 0;
        else m_active = 1'b0;
      end
    end else begin
      if (m_pos % (S + 1) == S)
        m_frame[m_pos / (S + 1)] = mux_in[m_pos / (S + 1)];
      if (m_pos == SCAN_CY - 1) begin
        m_hold = 1'b1; m_valid = 1'b1;
      end
      m_pos = m_pos + 1;
    end
  end

  function automatic logic [1:0] exp_sel();
    if (!m_active) return 2'd0;
    if (m_hold) return 2'd3;
    return 2'(m_pos / (S + 1));
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("model_sel", {6'd0, sel}, {6'd0, exp_sel()});
    check_output("model_frame", {4'd0, frame}, {4'd0, m_frame});
    check_output("model_valid", {7'd0, frame_valid}, {7'd0, m_valid});
    check_output("model_busy", {7'd0, busy}, {7'd0, m_active});
`ifdef MUX_SCAN_CNT_EN
    check_output("model_cnt", frame_cnt, m_cnt);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic s, input logic c, input logic r, input logic [3:0] m);
    start = s; cont = c; frame_ready = r; mux_in = m;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_valid && n < 200);
    if (!frame_valid) check_output("valid_timeout", 8'd0, 8'd1);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    tick(); tick();
    check_output("rst_sel", {6'd0, sel}, 8'd0);
    check_output("rst_frame", {4'd0, frame}, 8'd0);
    check_output("rst_valid", {7'd0, frame_valid}, 8'd0);
    check_output("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    tick();

    // Single scan, latency and return to idle.
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'b1010);
    tick();
    start = 1'b0;
    check_output("busy_after_start", {7'd0, busy}, 8'd1);
    lat = 1;
    while (!frame_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_output("latency", 8'(lat), 8'd13);
    check_output("single_frame", {4'd0, frame}, 8'b1010);
    tick();
    tick();
    check_output("idle_busy", {7'd0, busy}, 8'd0);
    check_output("idle_sel", {6'd0, sel}, 8'd0);

    // Backpressure in HOLD.
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1010);
    pulse_start();
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("bp_frame", {4'd0, frame}, 8'b1010);
      check_output("bp_valid", {7'd0, frame_valid}, 8'd1);
    end
    frame_ready = 1'b1;
    tick();
    check_output("bp_release", {7'd0, frame_valid}, 8'd0);
    tick();

    // Continuous scanning with data change between frames.
    apply_stimulus(1'b0, 1'b1, 1'b1, 4'b1000);
    pulse_start();
    wait_valid(lat);
    check_output("cont_frame0", {4'd0, frame}, 8'b1000);
    mux_in = 4'b0111;
    tick();
    check_output("cont_no_idle", {7'd0, busy}, 8'd1);
    check_output("cont_wrap_sel", {6'd0, sel}, 8'd0);
    wait_valid(lat);
    check_output("cont_gap", 8'(lat), 8'(SCAN_CY));
    check_output("cont_frame1", {4'd0, frame}, 8'b0111);
    cont = 1'b0;
    tick(); tick();
    check_output("cont_stop", {7'd0, busy}, 8'd0);

    // Reset during channel-2 settle.
    apply_stimulus(1'b0, 1'b0, 1'b1, 4'b1010);
    pulse_start();
    lat = 0;
    while (sel != 2'd2 && lat < 50) begin
      tick();
      lat++;
    end
    check_output("reach_ch2", {6'd0, sel}, 8'd2);
    rst = 1'b1;
    #1;
    check_output("mid_rst_sel", {6'd0, sel}, 8'd0);
    check_output("mid_rst_frame", {4'd0, frame}, 8'd0);
    check_output("mid_rst_valid", {7'd0, frame_valid}, 8'd0);
    check_output("mid_rst_busy", {7'd0, busy}, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    mux_in = 4'b0110;
    pulse_start();
    wait_valid(lat);
    check_output("post_rst_frame", {4'd0, frame}, 8'b0110);
    tick(); tick();

    // Stray start and frame_ready pulses during a scan.
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0101);
    tick();
    lat = 1;
    while (!frame_valid && lat < 100) begin
      start = (lat % 3 == 0);
      frame_ready = (lat % 2 == 1);
      tick();
      lat++;
    end
    start = 1'b0;
    frame_ready = 1'b1;
    check_output("ignored_latency", 8'(lat), 8'd13);
    check_output("ignored_frame", {4'd0, frame}, 8'b0101);
    tick(); tick();

`ifdef MUX_SCAN_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b1, 4'b0011);
    pulse_start();
    for (int f = 0; f < 257; f++) wait_valid(lat);
    cont = 1'b0;
    tick();
    check_output("cnt_wrap", frame_cnt, 8'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
